bus_master: RTL

//   Single-clock initiator for the shared read_bus/write_bus/data_bus fabric; drives the side that alu and other peripherals respond to.

---
 rtl/bus_master.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_master.sv
// rtl/bus_master.sv - bus initiator issuing read/write strobes and addresses for one transfer command
// Each command walks a fixed strobe sequence; every output is registered from the next state.
module bus_master #(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] NULL_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [WORD_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              read_clk,
  output logic              write_clk,
  output logic [ADDR_W-1:0] read_bus,
  output logic [ADDR_W-1:0] write_bus,
  inout  wire  [WORD_W-1:0] data_bus
);

  typedef enum logic [2:0] {IDLE, RD_SET, RD_PUL, WR_SET, WR_PUL, WR_END, RESP} state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_IMM  = 2'b10;

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WORD_W-1:0] imm_q;
  logic              data_oe;

  logic              accept;
  logic [1:0]        op_n;
  logic [ADDR_W-1:0] src_n;
  logic [ADDR_W-1:0] dst_n;

  assign accept = cmd_valid && cmd_ready;
  // Fields that the next state's outputs depend on: live command on the accept edge, latched copy after.
  assign op_n  = accept ? cmd_op  : op_q;
  assign src_n = accept ? cmd_src : src_q;
  assign dst_n = accept ? cmd_dst : dst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_MOVE, OP_READ: state_next = RD_SET;
            OP_IMM:           state_next = WR_SET;
            default:          state_next = RESP;
          endcase
        end
      end
      RD_SET:  state_next = RD_PUL;
      RD_PUL:  state_next = WR_SET;
      WR_SET:  state_next = WR_PUL;
      WR_PUL:  state_next = WR_END;
      WR_END:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_MOVE;
      src_q     <= NULL_ADDR;
      dst_q     <= NULL_ADDR;
      imm_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      read_clk  <= 1'b0;
      write_clk <= 1'b0;
      read_bus  <= NULL_ADDR;
      write_bus <= NULL_ADDR;
      data_oe   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        src_q   <= cmd_src;
        dst_q   <= cmd_dst;
        imm_q   <= cmd_imm;
        rsp_err <= (cmd_op == 2'b11);
        if (cmd_op == 2'b11) rsp_data <= '0;
      end
      if (state == WR_PUL) rsp_data <= data_bus;
      cmd_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      read_clk  <= (state_next == RD_PUL);
      write_clk <= (state_next == WR_PUL);
      read_bus  <= (state_next == RD_SET || state_next == RD_PUL) ? src_n : NULL_ADDR;
      // READ still pulses write_clk so the source releases data_bus, but addresses nobody.
      write_bus <= ((state_next == WR_SET || state_next == WR_PUL) && op_n != OP_READ)
                   ? dst_n : NULL_ADDR;
      data_oe   <= (op_n == OP_IMM) &&
                   (state_next == WR_SET || state_next == WR_PUL || state_next == WR_END);
    end
  end

  assign data_bus = data_oe ? imm_q : {WORD_W{1'bz}};

endmodule
